hdmi_period_scheduler: RTL and testbench

HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

---
 rtl/hdmi_pkg.sv | 37 +++
 rtl/hdmi_timing_counter.sv | 46 ++++
 rtl/hdmi_period_scheduler.sv | 127 ++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared TMDS period encodings, control-period constants and FSM state type
// for the HDMI period scheduler.
package hdmi_pkg;

    localparam int CNT_W        = 10;
    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int CTRL_MIN_LEN = 12;

    localparam logic [3:0] PREAMBLE_CTL = 4'b0001;

    typedef enum logic [1:0] {
        PERIOD_CTRL     = 2'd0,
        PERIOD_PREAMBLE = 2'd1,
        PERIOD_GUARD    = 2'd2,
        PERIOD_VIDEO    = 2'd3
    } period_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
        ST_PREAMBLE,
        ST_GUARD,
        ST_VIDEO
    } state_e;

    // IDLE is reported on the link as an ordinary control period.
    function automatic period_e state_period(input state_e s);
        case (s)
            ST_PREAMBLE: return PERIOD_PREAMBLE;
            ST_GUARD:    return PERIOD_GUARD;
            ST_VIDEO:    return PERIOD_VIDEO;
            default:     return PERIOD_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// Raster position counter: cntx/cnty with line/frame wrap, parked at a hold
// point while not advancing. Also exposes the next position for look-ahead.
module hdmi_timing_counter
    import hdmi_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int H_HOLD  = 640,
    parameter int V_HOLD  = 524
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [CNT_W-1:0] cntx,
    output logic [CNT_W-1:0] cnty,
    output logic [CNT_W-1:0] cntx_nx,
    output logic [CNT_W-1:0] cnty_nx
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

    always_comb begin
        cntx_nx = cntx;
        cnty_nx = cnty;
        if (advance) begin
            if (cntx == X_LAST) begin
                cntx_nx = '0;
                cnty_nx = (cnty == Y_LAST) ? '0 : cnty + CNT_W'(1);
            end else begin
                cntx_nx = cntx + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntx <= CNT_W'(H_HOLD);
            cnty <= CNT_W'(V_HOLD);
        end else begin
            cntx <= cntx_nx;
            cnty <= cnty_nx;
        end
    end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI raster timing and TMDS period scheduler (control/preamble/guard/video).
// state    | meaning
// IDLE     | parked at (H_ACTIVE, V_TOTAL-1), counters frozen, outputs quiet
// CTRL     | control period, counters running
// PREAMBLE | 8-cycle video preamble before an active line (ctl = 0001)
// GUARD    | 2-cycle leading video guard band
// VIDEO    | active pixels, cntx 0..H_ACTIVE-1
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [CNT_W-1:0] cntx,
    output logic [CNT_W-1:0] cnty,
    output logic             hsync,
    output logic             vsync,
    output logic [1:0]       period,
    output logic [3:0]       ctl,
    output logic             vde,
    output logic             pixel_req,
    output logic             frame_start,
    output logic             running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_FP + H_SYNC + H_BP < CTRL_MIN_LEN + PREAMBLE_LEN + GUARD_LEN) begin : g_blank_check
        $error("hdmi_period_scheduler: horizontal blanking too short for control, preamble and guard");
    end

    localparam logic [CNT_W-1:0] X_VEND  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] X_VLAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] X_PRE   = CNT_W'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
    localparam logic [CNT_W-1:0] X_GUARD = CNT_W'(H_TOTAL - GUARD_LEN);
    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_HOLD  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_ALAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_ON   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    state_e           state, state_nx;
    logic [CNT_W-1:0] nx, ny;
    logic             advance, next_active, at_hold, run_nx;
    period_e          period_q;

    assign advance = (state != ST_IDLE) || enable;

    hdmi_timing_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL),
        .H_HOLD (H_ACTIVE),
        .V_HOLD (V_TOTAL - 1)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .advance(advance),
        .cntx   (cntx),
        .cnty   (cnty),
        .cntx_nx(nx),
        .cnty_nx(ny)
    );

    // Decisions are made on the next position so registered outputs line up
    // with the counter values they describe.
    assign next_active = (ny == Y_HOLD) || (ny < Y_ALAST);
    assign at_hold     = (nx == X_VEND) && (ny == Y_HOLD);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:     if (enable) state_nx = ST_CTRL;
            ST_CTRL: begin
                if (at_hold && !enable)
                    state_nx = ST_IDLE;
                else if (nx == X_PRE && next_active)
                    state_nx = ST_PREAMBLE;
            end
            ST_PREAMBLE: if (nx == X_GUARD) state_nx = ST_GUARD;
            ST_GUARD:    if (nx == '0) state_nx = ST_VIDEO;
            ST_VIDEO:    if (nx == X_VEND) state_nx = ST_CTRL;
            default:     state_nx = ST_IDLE;
        endcase
    end

    assign run_nx = (state_nx != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            period_q    <= PERIOD_CTRL;
            ctl         <= '0;
            vde         <= 1'b0;
            pixel_req   <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nx;
            hsync       <= run_nx && (nx >= HS_ON) && (nx < HS_OFF);
            vsync       <= run_nx && (ny >= VS_ON) && (ny < VS_OFF);
            period_q    <= state_period(state_nx);
            ctl         <= (state_nx == ST_PREAMBLE) ? PREAMBLE_CTL : 4'b0000;
            vde         <= (state_nx == ST_VIDEO);
            pixel_req   <= ((state_nx == ST_GUARD) && (nx == X_LAST)) ||
                           ((state_nx == ST_VIDEO) && (nx < X_VLAST));
            frame_start <= run_nx && (nx == '0) && (ny == '0);
            running     <= run_nx;
        end
    end

    assign period = period_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler on a reduced raster
// (40 x 13 total, 16 x 6 active) so whole frames fit in a short run.
module tb_hdmi_period_scheduler;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 14;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int H_TOTAL  = 40;
    localparam int V_TOTAL  = 13;
    localparam int HOLD_X   = 16;
    localparam int HOLD_Y   = 12;

    // Hand-computed per-frame totals for this raster.
    localparam int FRAME_CYC  = 520;  // 40 * 13
    localparam int FRAME_VDE  = 96;   // 16 pixels * 6 lines
    localparam int FRAME_PRE  = 48;   // 8 cycles * 6 preambles (lines 12,0..4)
    localparam int FRAME_HSYN = 78;   // 6 cycles * 13 lines

    logic       clk, rst, enable;
    logic [9:0] cntx, cnty;
    logic       hsync, vsync, vde, pixel_req, frame_start, running;
    logic [1:0] period;
    logic [3:0] ctl;

    hdmi_period_scheduler #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cntx       (cntx),
        .cnty       (cnty),
        .hsync      (hsync),
        .vsync      (vsync),
        .period     (period),
        .ctl        (ctl),
        .vde        (vde),
        .pixel_req  (pixel_req),
        .frame_start(frame_start),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] cx;
        logic [9:0] cy;
        logic       hs;
        logic       vs;
        logic [1:0] per;
        logic [3:0] ctl;
        logic       vde;
        logic       preq;
        logic       fs;
        logic       run;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   timeouts = 0;
    bit   done = 0;
    int   mx, my;
    bit   mrun;

    // Reference raster model: position plus run flag; outputs derived purely
    // from where the beam is.
    function automatic obs_t model_out();
        obs_t o;
        bit   lact, nact;
        o = '0;
        o.cx = 10'(mx);
        o.cy = 10'(my);
        if (!mrun) return o;
        lact = (my < V_ACTIVE);
        nact = (my == V_TOTAL - 1) || (my + 1 < V_ACTIVE);
        o.hs = (mx >= 20) && (mx <= 25);
        o.vs = (my >= 8) && (my <= 9);
        if (lact && mx < H_ACTIVE)   o.per = 2'd3;
        else if (nact && mx >= 38)   o.per = 2'd2;
        else if (nact && mx >= 30)   o.per = 2'd1;
        else                         o.per = 2'd0;
        o.ctl  = (o.per == 2'd1) ? 4'b0001 : 4'b0000;
        o.vde  = (o.per == 2'd3);
        o.preq = (nact && mx == H_TOTAL - 1) || (lact && mx < H_ACTIVE - 1);
        o.fs   = (mx == 0) && (my == 0);
        o.run  = 1'b1;
        return o;
    endfunction

    task automatic model_reset();
        mx = HOLD_X;
        my = HOLD_Y;
        mrun = 0;
    endtask

    task automatic model_adv(input logic en);
        if (!mrun && !en) return;
        mrun = 1;
        if (mx == H_TOTAL - 1) begin
            mx = 0;
            my = (my == V_TOTAL - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        if (mx == HOLD_X && my == HOLD_Y && !en) mrun = 0;
    endtask

    task automatic step(input logic en);
        enable = en;
        @(posedge clk);
        #1;
        model_adv(en);
        exp_q.push_back(model_out());
    endtask

    task automatic run(input logic en, input int n);
        for (int i = 0; i < n; i++) step(en);
    endtask

    task automatic run_to(input logic en, input int x, input int y);
        for (int i = 0; i < 2000; i++) begin
            if (mx == x && my == y) return;
            step(en);
        end
        timeouts++;
    endtask

    task automatic run_to_idle();
        for (int i = 0; i < 2000; i++) begin
            if (!mrun) return;
            step(1'b0);
        end
        timeouts++;
    endtask

    // Reset lands 1 ns after an edge, so the next sample shows whether it
    // acted without waiting for a clock.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        exp_q.push_back(model_out());
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        model_reset();
        pulse_reset();
        run(1'b0, 5);
        run(1'b1, 24);
        run(1'b1, 2 * FRAME_CYC);
        run_to(1'b1, 10, 2);
        run_to_idle();
        run(1'b0, 8);
        run(1'b1, 24 + FRAME_CYC + 100);
        run_to(1'b1, 5, 3);
        run(1'b0, 50);
        run(1'b1, 600);
        run_to(1'b1, 7, 1);
        pulse_reset();
        run(1'b1, 24 + FRAME_CYC + 10);
        done = 1;
    end

    int   f_cyc = 0, f_vde = 0, f_pre = 0, f_hs = 0, frames = 0;
    bit   armed = 0;

    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{cntx, cnty, hsync, vsync, period, ctl, vde, pixel_req, frame_start, running};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL obs vec %0d: got x=%0d y=%0d hs=%0b vs=%0b per=%0d ctl=%b vde=%0b preq=%0b fs=%0b run=%0b, want x=%0d y=%0d hs=%0b vs=%0b per=%0d ctl=%b vde=%0b preq=%0b fs=%0b run=%0b",
                             n_vec, a.cx, a.cy, a.hs, a.vs, a.per, a.ctl, a.vde, a.preq, a.fs, a.run,
                             e.cx, e.cy, e.hs, e.vs, e.per, e.ctl, e.vde, e.preq, e.fs, e.run);
                end
            end
            if (!running) begin
                armed = 0;
            end else begin
                if (frame_start) begin
                    if (armed) begin
                        frames++;
                        n_vec++;
                        if (f_cyc != FRAME_CYC) begin
                            n_err++;
                            $display("FAIL frame_len: got %0d want %0d", f_cyc, FRAME_CYC);
                        end
                        n_vec++;
                        if (f_vde != FRAME_VDE) begin
                            n_err++;
                            $display("FAIL frame_vde: got %0d want %0d", f_vde, FRAME_VDE);
                        end
                        n_vec++;
                        if (f_pre != FRAME_PRE) begin
                            n_err++;
                            $display("FAIL frame_preamble: got %0d want %0d", f_pre, FRAME_PRE);
                        end
                        n_vec++;
                        if (f_hs != FRAME_HSYN) begin
                            n_err++;
                            $display("FAIL frame_hsync: got %0d want %0d", f_hs, FRAME_HSYN);
                        end
                    end
                    armed = 1;
                    f_cyc = 0; f_vde = 0; f_pre = 0; f_hs = 0;
                end
                f_cyc++;
                if (vde) f_vde++;
                if (period == 2'd1) f_pre++;
                if (hsync) f_hs++;
            end
            if (done) begin
                n_vec++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
                end
                n_vec++;
                if (timeouts != 0) begin
                    n_err++;
                    $display("FAIL wait_bound: got %0d expired want 0", timeouts);
                end
                n_vec++;
                if (frames < 4) begin
                    n_err++;
                    $display("FAIL frame_coverage: got %0d frames want >= 4", frames);
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
